// File: rtl/shift_pkg.sv
// shift_pkg: shared types for the shift arbiter (shifter op codes, arbiter FSM states)
package shift_pkg;
  typedef enum logic [1:0] {
    SH_SRL  = 2'b00,
    SH_SRA  = 2'b01,
    SH_SLL  = 2'b10,
    SH_RSVD = 2'b11
  } shift_op_e;
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_e;
endpackage

// File: rtl/barrel_shift.sv
// barrel_shift: combinational 32-bit shifter (SRL/SRA/SLL, reserved op passes A through)
//  a  : operand, sh : shift amount, op : shift_op_e, y : result
module barrel_shift
  import shift_pkg::*;
(
  input  logic [31:0] a,
  input  logic [4:0]  sh,
  input  shift_op_e   op,
  output logic [31:0] y
);
  logic [31:0] w_sra;
  // $unsigned keeps the arithmetic shift self-determined inside the unsigned ternary below
  assign w_sra = $unsigned($signed(a) >>> sh);
  always_comb y = op == SH_SRL ? a >> sh : op == SH_SRA ? w_sra : op == SH_SLL ? a << sh : a;
endmodule

// File: rtl/shift_arbiter_rr.sv
// rr_arbiter: combinational round-robin grant, searching from ptr+1 and wrapping
//  req : request vector, ptr : last granted index, en : grant enable
//  gnt : one-hot grant (zero when en=0 or no request), gnt_idx : binary grant index
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx
);
  logic            w_found;
  logic [ID_W-1:0] w_cand;
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (en && !w_found && req[w_cand]) begin
        w_found      = 1'b1;
        gnt[w_cand]  = 1'b1;
        gnt_idx      = w_cand;
      end
    end
  end
endmodule

// File: rtl/shift_arbiter.sv
// shift_arbiter: shares one barrel shifter among NUM_REQ valid/ready requesters, round-robin
//  clk/rst : clock, async active-high reset
//  req_valid/req_ready/req_a/req_b/req_op : per-requester request channel (packed, 32/32/2 bits each)
//  rsp_valid/rsp_ready/rsp_data/rsp_id/rsp_err : registered response channel
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*32-1:0]  req_a,
  input  logic [NUM_REQ*32-1:0]  req_b,
  input  logic [NUM_REQ*2-1:0]   req_op,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [31:0]            rsp_data,
  output logic [ID_W-1:0]        rsp_id,
  output logic                   rsp_err
);
  arb_state_e         r_state;
  logic [ID_W-1:0]    r_ptr;
  logic [ID_W-1:0]    w_idx;
  logic [NUM_REQ-1:0] w_gnt;
  logic               w_en;
  logic [31:0]        w_a;
  logic [31:0]        w_b;
  logic [1:0]         w_op_raw;
  shift_op_e          w_op;
  logic [31:0]        w_shift;
  // rst gates acceptance so nothing is handshaken while reset is held
  assign w_en      = !rst && (r_state == IDLE || rsp_ready);
  assign req_ready = w_gnt;
  assign rsp_valid = r_state == HOLD;
  assign w_op      = shift_op_e'(w_op_raw);
  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req(req_valid), .ptr(r_ptr), .en(w_en), .gnt(w_gnt), .gnt_idx(w_idx)
  );
  // AND-OR operand mux driven by the one-hot grant
  always_comb begin
    w_a      = '0;
    w_b      = '0;
    w_op_raw = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_a      = w_a | (req_a[32*k +: 32] & {32{w_gnt[k]}});
      w_b      = w_b | (req_b[32*k +: 32] & {32{w_gnt[k]}});
      w_op_raw = w_op_raw | (req_op[2*k +: 2] & {2{w_gnt[k]}});
    end
  end
  barrel_shift u_shift (.a(w_a), .sh(w_b[4:0]), .op(w_op), .y(w_shift));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_ptr    <= ID_W'(NUM_REQ - 1);
      rsp_data <= '0;
      rsp_id   <= '0;
      rsp_err  <= 1'b0;
    end else if (|w_gnt) begin
      r_state  <= HOLD;
      r_ptr    <= w_idx;
      rsp_data <= w_op == SH_RSVD ? w_a : w_shift;
      rsp_id   <= w_idx;
      rsp_err  <= w_op == SH_RSVD;
    end else if (rsp_ready) begin
      r_state  <= IDLE;
    end
  end
endmodule
